// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//   SPI master for the SPI slave + RAM wrapper. Turns one parallel command
//   (2-bit op + ADDR_SIZE payload) into one framed SPI transaction on
//   SS_n/MOSI. For op 11 (rd-data) it waits TURN_CYC idle cycles, then
//   captures an ADDR_SIZE-bit reply from MISO and returns it on rd_data.
//
//   Frame (cycle n = n clock edges after the accepting edge):
//     1            GUARD  SS_n low, MOSI 0
//     2            SEL    MOSI = op[1]
//     3..AS+4      SHIFT  MOSI = {op, data}, MSB first
//     (op 11 only) WAIT   TURN_CYC cycles, then RX for ADDR_SIZE cycles
//     last         END    SS_n high, busy high, rd_valid for a finished read
//
// Parameters
//   ADDR_SIZE  payload width (frame word is ADDR_SIZE+2 bits)
//   TURN_CYC   idle cycles between the last MOSI bit and the first MISO sample
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_op, cmd_data  command latched on the accepting edge
//   SS_n, MOSI, MISO  SPI pins (MSB first)
//   rd_valid/rd_data  one-cycle pulse with the captured read word
//   busy              high while a frame is on the wire or in its END cycle
//   rd_err            (SPI_MASTER_RDCHK_EN only) read-data without a prior
//                     read-address frame; pulses with rd_valid
//
// Configuration
//   SPI_MASTER_RDCHK_EN  when defined, op 11 is refused (not framed) unless an
//                        op 10 frame has been issued since the last op 11 or
//                        reset. Refusal answers with rd_valid + rd_err for one
//                        cycle and leaves rd_data unchanged.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TURN_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_SIZE-1:0] cmd_data,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic                 rd_valid,
    output logic [ADDR_SIZE-1:0] rd_data,
`ifdef SPI_MASTER_RDCHK_EN
    output logic                 rd_err,
`endif
    output logic                 busy
);

    localparam int unsigned FRAME_W = ADDR_SIZE + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam int unsigned TURN_W  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    // ST_ERR is only reachable when the read-address check is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GUARD = 3'd1,
        ST_SEL   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RX    = 3'd5,
        ST_END   = 3'd6,
        ST_ERR   = 3'd7
    } state_e;

    state_e                 state_q;
    state_e                 state_d;

    // Datapath registers
    logic [FRAME_W-1:0]     frame_q;
    logic                   rd_op_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [TURN_W-1:0]      turn_cnt_q;
    logic [ADDR_SIZE-1:0]   rx_q;
    logic [ADDR_SIZE-1:0]   rd_data_q;

    // Registered outputs and their next values
    logic                   ss_n_q;
    logic                   ss_n_d;
    logic                   mosi_q;
    logic                   mosi_d;
    logic                   cmd_ready_q;
    logic                   cmd_ready_d;
    logic                   busy_q;
    logic                   busy_d;
    logic                   rd_valid_q;
    logic                   rd_valid_d;

    logic                   accept_c;
    logic                   rd_block_c;

    assign accept_c = cmd_valid && (state_q == ST_IDLE);

`ifdef SPI_MASTER_RDCHK_EN
    logic                   rd_seen_q;
    logic                   rd_err_q;
    logic                   rd_err_d;

    // An op 11 with no read address issued since the last read is refused.
    assign rd_block_c = accept_c && (cmd_op == 2'b11) && !rd_seen_q;

    // Tracks whether a read address has been sent since the last read-data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_seen_q <= 1'b0;
        end else if (accept_c) begin
            if (cmd_op == 2'b10) begin
                rd_seen_q <= 1'b1;
            end else if (cmd_op == 2'b11) begin
                rd_seen_q <= 1'b0;
            end
        end
    end
`else
    assign rd_block_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_block_c) begin
                    state_d = ST_ERR;
                end else if (accept_c) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: state_d = ST_SEL;
            ST_SEL:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    state_d = rd_op_q ? ST_WAIT : ST_END;
                end
            end
            ST_WAIT: begin
                if (turn_cnt_q == '0) begin
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                if (bit_cnt_q == '0) begin
                    state_d = ST_END;
                end
            end
            ST_END:   state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: values for the cycle the FSM is about to enter
    always_comb begin
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        cmd_ready_d = 1'b0;
        busy_d      = 1'b0;
        rd_valid_d  = 1'b0;
`ifdef SPI_MASTER_RDCHK_EN
        rd_err_d    = 1'b0;
`endif
        case (state_d)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
            end
            ST_GUARD, ST_WAIT, ST_RX: begin
                ss_n_d = 1'b0;
                busy_d = 1'b1;
            end
            // SEL repeats op[1] as the slave's direction bit; SHIFT then
            // walks the whole frame word from its MSB.
            ST_SEL, ST_SHIFT: begin
                ss_n_d = 1'b0;
                busy_d = 1'b1;
                mosi_d = frame_q[FRAME_W-1];
            end
            ST_END: begin
                busy_d     = 1'b1;
                rd_valid_d = (state_q == ST_RX);
            end
            ST_ERR: begin
                rd_valid_d = 1'b1;
`ifdef SPI_MASTER_RDCHK_EN
                rd_err_d   = 1'b1;
`endif
            end
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

`ifdef SPI_MASTER_RDCHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_err = rd_err_q;
`endif

    // Frame word: latched on accept, shifted once per MOSI bit in SHIFT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            rd_op_q <= 1'b0;
        end else if (accept_c) begin
            frame_q <= {cmd_op, cmd_data};
            rd_op_q <= (cmd_op == 2'b11);
        end else if (state_d == ST_SHIFT) begin
            frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
        end
    end

    // Shared down-counter: bits left in SHIFT, samples left in RX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
        end else if (state_d != state_q) begin
            if (state_d == ST_SHIFT) begin
                bit_cnt_q <= CNT_W'(FRAME_W - 1);
            end else if (state_d == ST_RX) begin
                bit_cnt_q <= CNT_W'(ADDR_SIZE - 1);
            end
        end else if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
        end
    end

    // Turnaround counter for the WAIT gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_cnt_q <= '0;
        end else if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            turn_cnt_q <= TURN_W'(TURN_CYC - 1);
        end else if ((state_q == ST_WAIT) && (turn_cnt_q != '0)) begin
            turn_cnt_q <= turn_cnt_q - TURN_W'(1);
        end
    end

    // MISO capture; the final sample goes straight into rd_data on RX exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q      <= '0;
            rd_data_q <= '0;
        end else if (state_q == ST_RX) begin
            rx_q <= {rx_q[ADDR_SIZE-2:0], MISO};
            if (state_d == ST_END) begin
                rd_data_q <= {rx_q[ADDR_SIZE-2:0], MISO};
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule
